// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared definitions for the fetch stage.
//   ROM_COL_MAX  default ROM depth in 32-bit words
//   INST_NOP     canonical no-op encoding (addi x0,x0,0)
//   fetch_st_e   fetch FSM states (2-bit encodings IDLE/RUN/HALT)
//   fetch_ent_t  fetch-queue entry {pc, inst}
//   pc_ok()      aligned and inside the ROM
package instr_fetch_pkg;

  localparam int          WORDSIZE    = 32;
  localparam int          ROM_COL_MAX = 256;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_ST_IDLE = 2'd0,
    FETCH_ST_RUN  = 2'd1,
    FETCH_ST_HALT = 2'd2
  } fetch_st_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  function automatic logic pc_ok(input logic [31:0] pc, input logic [29:0] lim);
    return (pc[1:0] == 2'b00) && (pc[31:2] < lim);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch -> decode instruction handshake.
//   inst_valid  head of fetch queue valid
//   inst_ready  decode accepts head this cycle
//   inst_data   instruction word at head
//   inst_pc     byte PC of inst_data
// master = fetch side, slave = decode side.
interface instr_fetch_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (output inst_valid, inst_data, inst_pc, input inst_ready);
  modport slave  (input inst_valid, inst_data, inst_pc, output inst_ready);
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: synchronous FIFO holding fetched {pc, inst} entries.
//   clk, reset  clock, async active-high reset (contents cleared to 0)
//   push_i/data_i  write an entry (caller only pushes when !full_o or popping)
//   pop_i          drop the head (caller only pops when !empty_o)
//   flush_i        empty the queue; overrides push/pop
//   data_o         head entry, full_o / empty_o occupancy flags
module instr_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      // Storage is left alone; only the pointers matter once emptied.
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC + fetch stage in front of the instruction ROM.
//   clk, reset        clock, async active-high reset
//   rom_addr          ROM word index (= pc[31:2]), rom_data returned same cycle
//   redirect_valid/pc one-cycle flush-and-restart from execute
//   dec               instr_fetch_if.master toward decode (valid/ready)
//   fetch_fault       sticky: pc misaligned or beyond ROM, fetch halted
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall / perf_flush.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          ROM_WORDS   = ROM_COL_MAX
) (
  input  logic         clk,
  input  logic         reset,
  output logic [31:0]  rom_addr,
  input  logic [31:0]  rom_data,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  instr_fetch_if.master dec,
  output logic         fetch_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall,
  output logic [31:0]  perf_flush
`endif
);
  localparam logic [29:0] ROM_LIM = 30'(ROM_WORDS);

  fetch_st_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic        push, pop, flush, full, empty, redir;
  fetch_ent_t  head;

  instr_fetch_queue #(.DEPTH(QUEUE_DEPTH), .W($bits(fetch_ent_t))) u_queue (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .data_i ({pc_q, rom_data}),
    .pop_i  (pop),
    .flush_i(flush),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  // IDLE only spends the first post-reset cycle, so redirects are ignored there.
  assign redir          = redirect_valid && (state_q != FETCH_ST_IDLE);
  assign pop            = dec.inst_valid && dec.inst_ready && !redir;
  assign rom_addr       = {2'b00, pc_q[31:2]};
  assign dec.inst_valid = !empty;
  assign dec.inst_data  = head.inst;
  assign dec.inst_pc    = head.pc;
  assign fetch_fault    = fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_ST_IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      FETCH_ST_IDLE: state_d = FETCH_ST_RUN;
      FETCH_ST_RUN: begin
        if (redir) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
        end else if (!pc_ok(pc_q, ROM_LIM)) begin
          state_d = FETCH_ST_HALT;
          fault_d = 1'b1;
        end else if (!full || pop) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
        end
      end
      FETCH_ST_HALT: begin
        // Queue keeps draining; only a good redirect restarts fetch.
        if (redir) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
          if (pc_ok(redirect_pc, ROM_LIM)) begin
            state_d = FETCH_ST_RUN;
            fault_d = 1'b0;
          end
        end
      end
      default: state_d = FETCH_ST_IDLE;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic        stall;
  logic [31:0] perf_fetched_q, perf_stall_q, perf_flush_q;

  assign stall = (state_q == FETCH_ST_RUN) && !redir && pc_ok(pc_q, ROM_LIM) && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
    end else begin
      if (push)  perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall) perf_stall_q   <= perf_stall_q + 32'd1;
      if (flush) perf_flush_q   <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed + random stimulus for instr_fetch against a
// transaction-level model (queue of {pc,inst}, pc, halted flag).
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam int          RW     = 8;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_addr, rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, perf_flush;
`endif

  instr_fetch_if dec_if();
  logic [31:0] rom_mem [32];

  assign rom_data = (rom_addr < 32'd32) ? rom_mem[rom_addr[4:0]] : 32'h0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH), .ROM_WORDS(RW)) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec           (dec_if),
    .fetch_fault   (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall),
    .perf_flush    (perf_flush)
`endif
  );

  // ---------------- reference model ----------------
  fetch_ent_t  mq[$];
  logic [31:0] mpc;
  bit          mstarted, mhalt, mfault;
  int unsigned m_fetched, m_stall, m_flush;
  int          n_chk = 0, n_fail = 0;

  function automatic bit in_range(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < 32'(RW));
  endfunction

  task automatic model_reset();
    mq.delete();
    mpc = RST_PC;
    mstarted = 0; mhalt = 0; mfault = 0;
    m_fetched = 0; m_stall = 0; m_flush = 0;
  endtask

  // One clock edge worth of fetch behaviour.
  task automatic model_update();
    if (!mstarted) begin
      mstarted = 1;
      return;
    end
    if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc;
      m_flush++;
      if (mhalt && in_range(redirect_pc)) begin
        mhalt = 0; mfault = 0;
      end
      return;
    end
    if (mq.size() > 0 && dec_if.inst_ready) void'(mq.pop_front());
    if (!mhalt) begin
      if (!in_range(mpc)) begin
        mhalt = 1; mfault = 1;
      end else if (mq.size() < DEPTH) begin
        mq.push_back('{pc: mpc, inst: rom_mem[5'(mpc >> 2)]});
        mpc += 32'd4;
        m_fetched++;
      end else begin
        m_stall++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", {31'b0, dec_if.inst_valid}, 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("data", dec_if.inst_data, mq[0].inst);
      chk("pc", dec_if.inst_pc, mq[0].pc);
    end
    chk("fault", {31'b0, fetch_fault}, {31'b0, mfault});
    chk("rom_addr", rom_addr, {2'b00, mpc[31:2]});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
    chk("perf_flush", perf_flush, m_flush);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, dec_if.inst_valid}, 32'h0);
    chk({tag, "_data"}, dec_if.inst_data, 32'h0);
    chk({tag, "_pc"}, dec_if.inst_pc, 32'h0);
    chk({tag, "_fault"}, {31'b0, fetch_fault}, 32'h0);
    chk({tag, "_rom_addr"}, rom_addr, {2'b00, RST_PC[31:2]});
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rom_mem[k] = 32'(k + 1);
    dec_if.inst_ready = 1'b0;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // 1: streaming, one instruction per cycle
    dec_if.inst_ready = 1'b1;
    step();
    chk("t1_idle_valid", {31'b0, dec_if.inst_valid}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t1_data", dec_if.inst_data, 32'(k + 1));
      chk("t1_pc", dec_if.inst_pc, 32'(4 * k));
    end

    // 2: back-pressure from a fresh start at 0
    dec_if.inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("t2_hold_addr", rom_addr, 32'h2);
    chk("t2_hold_data", dec_if.inst_data, 32'h1);
    chk("t2_hold_pc", dec_if.inst_pc, 32'h0);
    dec_if.inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_resume_data", dec_if.inst_data, 32'(k + 2));
    end

    // 3: redirect with a full queue
    dec_if.inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    chk("t3_flush_valid", {31'b0, dec_if.inst_valid}, 32'h0);
    redirect_valid = 1'b0;
    dec_if.inst_ready = 1'b1;
    step();
    chk("t3_new_pc", dec_if.inst_pc, 32'h10);
    chk("t3_new_data", dec_if.inst_data, 32'h5);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_stall", perf_stall, 32'd3);
`endif

    // 4: run off the end of the ROM, then recover
    for (int k = 0; k < 6; k++) step();
    chk("t4_fault", {31'b0, fetch_fault}, 32'h1);
    chk("t4_drained", {31'b0, dec_if.inst_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    chk("t4_fault_clr", {31'b0, fetch_fault}, 32'h0);
    redirect_valid = 1'b0;
    step();
    chk("t4_recover_pc", dec_if.inst_pc, 32'h0);

    // 5: misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    redirect_valid = 1'b0;
    step();
    chk("t5_fault", {31'b0, fetch_fault}, 32'h1);
    step();
    chk("t5_no_enq", {31'b0, dec_if.inst_valid}, 32'h0);

    // random traffic with random ROM contents
    for (int k = 0; k < 32; k++) rom_mem[k] = $urandom;
    for (int k = 0; k < 400; k++) begin
      dec_if.inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = 32'($urandom_range(0, 11)) * 32'd4 +
                    (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      step();
    end

    // reset mid-stream with entries queued
    dec_if.inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      dec_if.inst_ready = ($urandom_range(0, 1) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = 32'($urandom_range(0, 9)) * 32'd4;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
